note_entry_capture: RTL and testbench

Front-end stage feeding the melody recognizer FSM. It synchronizes the raw OK push-button and the tone/note switches, then debounces the button. For each clean press it emits one single-cycle `ok` strobe, together with the `tone`/`note` values captured at that instant. The recognizer consumes `ok`, `tone` and `note` directly; `entry_count` and `locked` are for board LEDs and debug.

---
 rtl/note_entry_pkg.sv | 36 +++
 rtl/note_entry_capture_sync_ff2.sv | 34 +++
 rtl/note_entry_capture.sv | 179 +++++++++++++++++
 tb/tb_note_entry_capture.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_entry_pkg.sv
// ---------------------------------------------------------------------------
// note_entry_pkg
// Shared definitions for the note entry front end and the melody recognizer:
//   - state_e     : debounce FSM states
//   - NOTE_*      : 3-bit note switch codes (NOTE_X = rest)
//   - TONE_*      : tone switch values (1 = sharp)
//   - cnt_width() : debounce counter width, never narrower than 1 bit
// ---------------------------------------------------------------------------
package note_entry_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        FIRE         = 3'd2,
        HELD         = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_e;

    localparam logic [2:0] NOTE_X = 3'd0;
    localparam logic [2:0] NOTE_C = 3'd1;
    localparam logic [2:0] NOTE_D = 3'd2;
    localparam logic [2:0] NOTE_E = 3'd3;
    localparam logic [2:0] NOTE_F = 3'd4;
    localparam logic [2:0] NOTE_G = 3'd5;
    localparam logic [2:0] NOTE_A = 3'd6;
    localparam logic [2:0] NOTE_B = 3'd7;

    localparam logic TONE_NATURAL = 1'b0;
    localparam logic TONE_SHARP   = 1'b1;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/note_entry_capture_sync_ff2.sv
// ---------------------------------------------------------------------------
// sync_ff2
// Two-flop synchronizer for asynchronous inputs, parameterized width.
// Ports:
//   clk   in          system clock
//   reset in          synchronous, active-high; clears both stages
//   d     in  WIDTH   asynchronous input
//   q     out WIDTH   synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync_ff2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/note_entry_capture.sv
// ---------------------------------------------------------------------------
// note_entry_capture
// Synchronizes the OK button and the tone/note switches, debounces the
// button and emits one single-cycle ok strobe per clean press, with the
// switch values captured on the same edge.
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required on press and on release (>=1)
//   MAX_ENTRIES      entries per melody attempt (1..7)
// Ports:
//   clk          in     system clock
//   reset        in     synchronous, active-high
//   btn_ok_raw   in     raw OK button, active-high, bouncy
//   sw_tone_raw  in     raw tone switch (1 = sharp)
//   sw_note_raw  in  3  raw note switches (000 = rest, 001 = C .. 111 = B)
//   ok           out    one-cycle accept strobe
//   tone         out    captured tone
//   note         out 3  captured note
//   entry_count  out 3  accepted presses since reset, saturating
//   locked       out    entry limit reached
// Build option:
//   NOTE_ENTRY_LOCKOUT_EN  when defined, presses beyond MAX_ENTRIES are
//                          swallowed and locked reports the limit; when
//                          undefined every press strobes and locked is 0.
// ---------------------------------------------------------------------------
module note_entry_capture
    import note_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_ENTRIES     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ok_raw,
    input  logic       sw_tone_raw,
    input  logic [2:0] sw_note_raw,
    output logic       ok,
    output logic       tone,
    output logic [2:0] note,
    output logic [2:0] entry_count,
    output logic       locked
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       MAX_CNT  = 3'(MAX_ENTRIES);

    logic       btn_s;
    logic [3:0] sw_s;

    sync_ff2 #(.WIDTH(1)) u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d     (btn_ok_raw),
        .q     (btn_s)
    );

    // Bit 3 is the tone, bits 2:0 the note.
    sync_ff2 #(.WIDTH(4)) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     ({sw_tone_raw, sw_note_raw}),
        .q     (sw_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             tone_q, tone_d;
    logic [2:0]       note_q, note_d;
    logic [2:0]       count_q, count_d;
    logic             accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ok_d    = 1'b0;
        tone_d  = tone_q;
        note_d  = note_q;
        count_d = count_q;
        accept  = 1'b0;

        // Every state change clears the counter so each wait starts fresh.
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FIRE: begin
                state_d = HELD;
                cnt_d   = '0;
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = HELD;
                cnt_d   = '0;
            end
        endcase

        // FIRE is only reachable from PRESS_WAIT, so state_d == FIRE marks
        // the single edge on which the press is accepted.
        if (state_d == FIRE) begin
            if (count_q < MAX_CNT) begin
                count_d = count_q + 3'd1;
            end
`ifdef NOTE_ENTRY_LOCKOUT_EN
            accept = (count_q != MAX_CNT);
`else
            accept = 1'b1;
`endif
            if (accept) begin
                ok_d   = 1'b1;
                tone_d = sw_s[3];
                note_d = sw_s[2:0];
            end
        end
    end

    // Reset parks in HELD so the button must be seen released for a full
    // debounce period before any press can be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HELD;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            tone_q  <= 1'b0;
            note_q  <= 3'b000;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            tone_q  <= tone_d;
            note_q  <= note_d;
            count_q <= count_d;
        end
    end

    assign ok          = ok_q;
    assign tone        = tone_q;
    assign note        = note_q;
    assign entry_count = count_q;

`ifdef NOTE_ENTRY_LOCKOUT_EN
    assign locked = (count_q == MAX_CNT);
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_note_entry_capture.sv
// ---------------------------------------------------------------------------
// tb_note_entry_capture
// Directed bench for note_entry_capture with DEBOUNCE_CYCLES=4 and
// MAX_ENTRIES=6. Inputs are driven and outputs sampled 1 time unit after
// each rising clock edge. Expectations for the entry limit follow
// NOTE_ENTRY_LOCKOUT_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_note_entry_capture;

    logic       clk;
    logic       reset;
    logic       btn_ok_raw;
    logic       sw_tone_raw;
    logic [2:0] sw_note_raw;
    logic       ok;
    logic       tone;
    logic [2:0] note;
    logic [2:0] entry_count;
    logic       locked;

    int checks;
    int errors;

    // Running edge counter and strobe bookkeeping.
    int         cycle_num;
    int         ok_count;
    int         last_ok_cycle;
    logic       last_ok_tone;
    logic [2:0] last_ok_note;

    note_entry_capture #(
        .DEBOUNCE_CYCLES (4),
        .MAX_ENTRIES     (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_ok_raw  (btn_ok_raw),
        .sw_tone_raw (sw_tone_raw),
        .sw_note_raw (sw_note_raw),
        .ok          (ok),
        .tone        (tone),
        .note        (note),
        .entry_count (entry_count),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges, recording every cycle in which ok is high.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cycle_num++;
            if (ok === 1'b1) begin
                ok_count++;
                last_ok_cycle = cycle_num;
                last_ok_tone  = tone;
                last_ok_note  = note;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run_cycles(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic t, input logic [2:0] n, input int hold, input int rel);
        sw_tone_raw = t;
        sw_note_raw = n;
        btn_ok_raw  = 1'b1;
        run_cycles(hold);
        btn_ok_raw  = 1'b0;
        run_cycles(rel);
    endtask

    task automatic test_reset();
        btn_ok_raw  = 1'b0;
        sw_tone_raw = 1'b1;
        sw_note_raw = 3'b111;
        reset       = 1'b1;
        run_cycles(3);
        checks++;
        if (ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ok: got %b expected 0", ok);
        end
        checks++;
        if (tone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tone: got %b expected 0", tone);
        end
        checks++;
        if (note !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_note: got %b expected 000", note);
        end
        checks++;
        if (entry_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", entry_count);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_locked: got %b expected 0", locked);
        end
        reset = 1'b0;
        sw_tone_raw = 1'b0;
        sw_note_raw = 3'b000;
        run_cycles(10);
    endtask

    task automatic test_clean_press();
        int start_ok;
        int c0;
        start_ok    = ok_count;
        sw_tone_raw = 1'b0;
        sw_note_raw = 3'b100;
        c0          = cycle_num;
        btn_ok_raw  = 1'b1;
        run_cycles(12);
        checks++;
        if (ok_count - start_ok !== 1) begin
            errors++;
            $display("[TB] FAIL clean_ok_count: got %0d expected 1", ok_count - start_ok);
        end
        checks++;
        if (last_ok_cycle - c0 !== 7) begin
            errors++;
            $display("[TB] FAIL clean_latency: got %0d expected 7", last_ok_cycle - c0);
        end
        checks++;
        if (last_ok_note !== 3'b100) begin
            errors++;
            $display("[TB] FAIL clean_note_at_strobe: got %b expected 100", last_ok_note);
        end
        checks++;
        if (last_ok_tone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clean_tone_at_strobe: got %b expected 0", last_ok_tone);
        end
        checks++;
        if (entry_count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL clean_count: got %0d expected 1", entry_count);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clean_locked: got %b expected 0", locked);
        end
        btn_ok_raw = 1'b0;
        run_cycles(10);
        checks++;
        if (ok_count - start_ok !== 1) begin
            errors++;
            $display("[TB] FAIL clean_after_release: got %0d expected 1", ok_count - start_ok);
        end
    endtask

    task automatic test_bounce_press();
        int start_ok;
        start_ok    = ok_count;
        sw_tone_raw = 1'b1;
        sw_note_raw = 3'b010;
        btn_ok_raw = 1'b1; run_cycles(2);
        btn_ok_raw = 1'b0; run_cycles(1);
        btn_ok_raw = 1'b1; run_cycles(2);
        btn_ok_raw = 1'b0; run_cycles(4);
        checks++;
        if (ok_count - start_ok !== 0) begin
            errors++;
            $display("[TB] FAIL bounce_rejected: got %0d strobes expected 0", ok_count - start_ok);
        end
        btn_ok_raw = 1'b1; run_cycles(10);
        btn_ok_raw = 1'b0; run_cycles(10);
        checks++;
        if (ok_count - start_ok !== 1) begin
            errors++;
            $display("[TB] FAIL bounce_then_hold: got %0d strobes expected 1", ok_count - start_ok);
        end
        checks++;
        if (note !== 3'b010) begin
            errors++;
            $display("[TB] FAIL bounce_note: got %b expected 010", note);
        end
        checks++;
        if (tone !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bounce_tone: got %b expected 1", tone);
        end
        checks++;
        if (entry_count !== 3'd2) begin
            errors++;
            $display("[TB] FAIL bounce_count: got %0d expected 2", entry_count);
        end
    endtask

    task automatic test_hold_toggle();
        int start_ok;
        start_ok    = ok_count;
        sw_tone_raw = 1'b0;
        sw_note_raw = 3'b001;
        btn_ok_raw  = 1'b1;
        run_cycles(9);
        sw_tone_raw = 1'b1;
        sw_note_raw = 3'b111;
        run_cycles(41);
        checks++;
        if (ok_count - start_ok !== 1) begin
            errors++;
            $display("[TB] FAIL hold_single_strobe: got %0d expected 1", ok_count - start_ok);
        end
        checks++;
        if (note !== 3'b001) begin
            errors++;
            $display("[TB] FAIL hold_note_kept: got %b expected 001", note);
        end
        checks++;
        if (tone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_tone_kept: got %b expected 0", tone);
        end
        checks++;
        if (entry_count !== 3'd3) begin
            errors++;
            $display("[TB] FAIL hold_count: got %0d expected 3", entry_count);
        end
        btn_ok_raw = 1'b0;
        run_cycles(10);
    endtask

    task automatic test_release_bounce();
        int start_ok;
        int c0;
        start_ok    = ok_count;
        sw_tone_raw = 1'b1;
        sw_note_raw = 3'b101;
        btn_ok_raw = 1'b1; run_cycles(12);
        btn_ok_raw = 1'b0; run_cycles(2);
        btn_ok_raw = 1'b1; run_cycles(1);
        btn_ok_raw = 1'b0; run_cycles(10);
        checks++;
        if (ok_count - start_ok !== 1) begin
            errors++;
            $display("[TB] FAIL release_bounce_strobes: got %0d expected 1", ok_count - start_ok);
        end
        sw_tone_raw = 1'b0;
        sw_note_raw = 3'b110;
        c0          = cycle_num;
        btn_ok_raw  = 1'b1;
        run_cycles(12);
        btn_ok_raw  = 1'b0;
        run_cycles(10);
        checks++;
        if (ok_count - start_ok !== 2) begin
            errors++;
            $display("[TB] FAIL release_next_press: got %0d expected 2", ok_count - start_ok);
        end
        checks++;
        if (last_ok_cycle - c0 !== 7) begin
            errors++;
            $display("[TB] FAIL release_next_latency: got %0d expected 7", last_ok_cycle - c0);
        end
        checks++;
        if (note !== 3'b110) begin
            errors++;
            $display("[TB] FAIL release_next_note: got %b expected 110", note);
        end
    endtask

    task automatic test_reset_held();
        int start_ok;
        start_ok    = ok_count;
        sw_tone_raw = 1'b1;
        sw_note_raw = 3'b011;
        btn_ok_raw  = 1'b1;
        run_cycles(3);
        do_reset();
        run_cycles(20);
        checks++;
        if (ok_count - start_ok !== 0) begin
            errors++;
            $display("[TB] FAIL held_through_reset: got %0d strobes expected 0", ok_count - start_ok);
        end
        checks++;
        if (entry_count !== 3'd0) begin
            errors++;
            $display("[TB] FAIL held_count_cleared: got %0d expected 0", entry_count);
        end
        btn_ok_raw = 1'b0;
        run_cycles(6);
        btn_ok_raw = 1'b1;
        run_cycles(12);
        btn_ok_raw = 1'b0;
        run_cycles(10);
        checks++;
        if (ok_count - start_ok !== 1) begin
            errors++;
            $display("[TB] FAIL held_repress: got %0d strobes expected 1", ok_count - start_ok);
        end
        checks++;
        if (entry_count !== 3'd1) begin
            errors++;
            $display("[TB] FAIL held_repress_count: got %0d expected 1", entry_count);
        end
    endtask

    task automatic test_entry_limit();
        int         start_ok;
        int         exp_oks;
        logic       exp_locked;
        logic       exp_tone;
        logic [2:0] exp_note;
        logic [2:0] n;
`ifdef NOTE_ENTRY_LOCKOUT_EN
        exp_oks    = 6;
        exp_locked = 1'b1;
        exp_tone   = 1'b1;
        exp_note   = 3'b110;
`else
        exp_oks    = 7;
        exp_locked = 1'b0;
        exp_tone   = 1'b0;
        exp_note   = 3'b111;
`endif
        do_reset();
        run_cycles(10);
        start_ok = ok_count;
        for (int i = 0; i < 7; i++) begin
            n = 3'(i + 1);
            press(i[0], n, 10, 10);
            if (i == 4) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL limit_locked_early: got %b expected 0", locked);
                end
            end
        end
        checks++;
        if (ok_count - start_ok !== exp_oks) begin
            errors++;
            $display("[TB] FAIL limit_strobes: got %0d expected %0d", ok_count - start_ok, exp_oks);
        end
        checks++;
        if (entry_count !== 3'd6) begin
            errors++;
            $display("[TB] FAIL limit_count: got %0d expected 6", entry_count);
        end
        checks++;
        if (locked !== exp_locked) begin
            errors++;
            $display("[TB] FAIL limit_locked: got %b expected %b", locked, exp_locked);
        end
        checks++;
        if (note !== exp_note || tone !== exp_tone) begin
            errors++;
            $display("[TB] FAIL limit_capture: got tone %b note %b expected tone %b note %b",
                     tone, note, exp_tone, exp_note);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cycle_num     = 0;
        ok_count      = 0;
        last_ok_cycle = 0;
        last_ok_tone  = 1'b0;
        last_ok_note  = 3'b000;
        reset         = 1'b1;
        btn_ok_raw    = 1'b0;
        sw_tone_raw   = 1'b0;
        sw_note_raw   = 3'b000;

        $display("[TB] starting note_entry_capture bench");
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_hold_toggle();
        test_release_bounce();
        test_reset_held();
        test_entry_limit();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
